// File: rtl/mips_cpu_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// then a sign-fixup cycle that registers quotient (LO), remainder (HI) and div_by_zero.
module mips_cpu_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    // Full WIDTH+1 shift keeps the top remainder bit, needed when divisor >= 2^(WIDTH-1).
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        dvd_raw_d     = dvd_raw_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvs_d     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    dvd_raw_d = dividend;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dbz_d     = (divisor == '0);
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Zero divisor: force MIPS-style result for both signed and unsigned.
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_raw_q;
                end else begin
                    quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                end
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            dvd_raw_q     <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            dvd_raw_q     <= dvd_raw_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Self-checking bench for mips_cpu_divider: cycle-level latency model plus
// arithmetic reference, directed MIPS corner cases and randomized operations.
module tb_mips_cpu_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    mips_cpu_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Expected result {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint sa, sb, qq, rr;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (!s) return {1'b0, a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, qq[W-1:0], rr[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: an accepted start makes busy last W+1 cycles, then one done cycle.
    int           m_cnt = 0;
    logic         m_valid = 1'b0;
    logic         m_done = 1'b0;
    logic [2*W:0] m_pend = '0;
    logic [2*W:0] m_out = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b1;
                m_cnt   = 0;
                m_done  = 1'b0;
                m_out   = '0;
            end else if (m_valid) begin
                m_done = 1'b0;
                if (m_cnt == 0) begin
                    if (start) begin
                        m_cnt  = W + 1;
                        m_pend = ref_div(dividend, divisor, is_signed);
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done = 1'b1;
                        m_out  = m_pend;
                    end
                end
            end
            #1;
            if (m_valid) begin
                check("busy", W'(busy), W'(m_cnt > 0));
                check("done", W'(done), W'(m_done));
                check("quotient", quotient, m_out[2*W-1:W]);
                check("remainder", remainder, m_out[W-1:0]);
                check("div_by_zero", W'(div_by_zero), W'(m_out[2*W]));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_done: no done within 100 cycles at %0t", $time);
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input bit chk_lat);
        int cyc;
        start_op(a, b, s);
        wait_done(cyc);
        if (chk_lat) check({name, "_latency"}, W'(cyc), W'(W + 1));
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_z"}, W'(div_by_zero), W'(ez));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] a, b;
        logic s;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_q", quotient, 32'h0);
        check("reset_busy", W'(busy), 32'h0);

        run_lit("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
        run_lit("sdiv_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_lit("udiv_m7_2", 32'hFFFFFFF9, 32'h2, 1'b0, 32'h7FFFFFFC, 32'h1, 1'b0, 1'b1);
        run_lit("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b1);
        run_lit("udiv_max_1", 32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        run_lit("udiv_big_dvs", 32'hFFFFFFFE, 32'h80000001, 1'b0, 32'h1, 32'h7FFFFFFD, 1'b0, 1'b1);
        run_lit("sdiv_m5_0", 32'hFFFFFFFB, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b1);
        // Started in the done cycle of the previous op, so it is accepted immediately.
        run_lit("udiv_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);

        // A start pulse while busy must be ignored.
        start_op(32'd20, 32'd6, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ignored_start_q", quotient, 32'd3);
        check("ignored_start_r", remainder, 32'd2);

        // Reset mid-operation aborts with no done pulse.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_q", quotient, 32'h0);
        check("abort_r", remainder, 32'h0);
        check("abort_done", W'(done), 32'h0);
        run_lit("udiv_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = -W'($urandom_range(1, 15));
                3: begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            start_op(a, b, s);
            wait_done(cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
